// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel fetch handshake between the timing engine and an external pixel source.
interface vga_sync_gen_if #(
  parameter int COLOR_W = 1,
  parameter int CNT_W = 10
);
  logic pix_req;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic [3*COLOR_W-1:0] pix_rgb;
  modport master(output pix_req, pix_x, pix_y, input pix_rgb);
  modport slave(input pix_req, pix_x, pix_y, output pix_rgb);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: programmable VGA timing with pixel fetch, test patterns and registered blank-gated pins.
module vga_sync_gen #(
  parameter int COLOR_W = 1,
  parameter int PIX_DIV = 2,
  parameter int CNT_W = 10,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit H_POL = 1'b0,
  parameter bit V_POL = 1'b0
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic enable,
  input  logic [1:0] pattern_mode,
  vga_sync_gen_if.master pix,
  output logic [COLOR_W-1:0] vga_red,
  output logic [COLOR_W-1:0] vga_green,
  output logic [COLOR_W-1:0] vga_blue,
  output logic vga_hsync,
  output logic vga_vsync,
  output logic frame_start
);
  localparam int DIV_W = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] HV = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] HT = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] VV = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] VT = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] BW = CNT_W'(H_VIS / 8 - 1);
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt, v_cnt, bar_cnt;
  logic [2:0] bar_idx, bar_d;
  logic tick, h_end, visible, hs_act, vs_act;
  logic vis_d, hs_d, vs_d, chk_d;
  logic [3*COLOR_W-1:0] sel;
  assign tick = enable && div_cnt == DIV_END;
  assign h_end = h_cnt == HT;
  assign visible = h_cnt < HV && v_cnt < VV;
  assign hs_act = h_cnt >= HS0 && h_cnt <= HS1;
  assign vs_act = v_cnt >= VS0 && v_cnt <= VS1;
  assign pix.pix_req = tick && visible && pattern_mode == 2'd0;
  assign pix.pix_x = h_cnt;
  assign pix.pix_y = v_cnt;
  assign frame_start = tick && h_cnt == '0 && v_cnt == '0;
  assign sel = pattern_mode == 2'd0 ? pix.pix_rgb :
               pattern_mode == 2'd1 ? {{COLOR_W{bar_d[2]}}, {COLOR_W{bar_d[1]}}, {COLOR_W{bar_d[0]}}} :
               pattern_mode == 2'd2 ? {3*COLOR_W{chk_d}} : '1;
  // bar_idx tracks min(h_cnt / (H_VIS/8), 7) incrementally so no divider is needed
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      bar_d <= '0;
      vis_d <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
      chk_d <= 1'b0;
      vga_red <= '0;
      vga_green <= '0;
      vga_blue <= '0;
      vga_hsync <= ~H_POL;
      vga_vsync <= ~V_POL;
    end else begin
      if (enable) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        h_cnt <= h_end ? '0 : h_cnt + CNT_W'(1);
        if (h_end) v_cnt <= v_cnt == VT ? '0 : v_cnt + CNT_W'(1);
        bar_cnt <= (h_end || bar_cnt == BW) ? '0 : bar_cnt + CNT_W'(1);
        if (h_end) bar_idx <= '0;
        else if (bar_cnt == BW && bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        vis_d <= visible;
        hs_d <= hs_act;
        vs_d <= vs_act;
        chk_d <= h_cnt[4] ^ v_cnt[4];
        bar_d <= bar_idx;
        vga_hsync <= hs_d ? H_POL : ~H_POL;
        vga_vsync <= vs_d ? V_POL : ~V_POL;
        {vga_red, vga_green, vga_blue} <= vis_d ? sel : '0;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench on a scaled-down timing (40x25, PIX_DIV=2, COLOR_W=4).
module tb_vga_sync_gen;
  localparam int CW = 4, PD = 2, CNT_W = 10;
  localparam int HV = 32, HF = 2, HS = 3, HB = 3, VV = 20, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
  localparam logic [3*CW+1:0] IDLE = 14'b11;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [CW-1:0] red, green, blue;
  logic hsync, vsync, fs;
  int checks = 0, fails = 0;
  int m_div = 0, m_h = 0, m_v = 0;
  logic [3*CW+1:0] q[$];
  vga_sync_gen_if #(.COLOR_W(CW), .CNT_W(CNT_W)) pix();
  vga_sync_gen #(.COLOR_W(CW), .PIX_DIV(PD), .CNT_W(CNT_W), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS),
    .H_BP(HB), .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0)) dut (
    .clk_50mhz(clk), .rst(rst), .enable(enable), .pattern_mode(mode), .pix(pix),
    .vga_red(red), .vga_green(green), .vga_blue(blue), .vga_hsync(hsync), .vga_vsync(vsync),
    .frame_start(fs));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", nm, act, exp, m_h, m_v, $time);
    end
  endtask
  function automatic logic [3*CW+1:0] exp_pins(input int x, input int y, input logic [1:0] md);
    logic [CW-1:0] r, g, b;
    int bar;
    bar = x / (HV / 8) > 7 ? 7 : x / (HV / 8);
    r = '1; g = '1; b = '1;
    if (md == 2'd0) begin r = CW'(x % 16); g = CW'(y % 16); b = CW'(10); end
    else if (md == 2'd1) begin r = {CW{bar[2]}}; g = {CW{bar[1]}}; b = {CW{bar[0]}}; end
    else if (md == 2'd2) begin r = ((x / 16) % 2 != (y / 16) % 2) ? '1 : '0; g = r; b = r; end
    if (!(x < HV && y < VV)) begin r = '0; g = '0; b = '0; end
    return {r, g, b, !(x >= HV + HF && x < HV + HF + HS), !(y >= VV + VF && y < VV + VF + VS)};
  endfunction
  // Reference timing model and scoreboard: pins at tick k show the position pushed at tick k-2
  always @(negedge clk) begin
    logic tk, vis;
    logic [3*CW+1:0] e;
    if (rst) begin
      m_div = 0; m_h = 0; m_v = 0;
      q = {IDLE, IDLE};
      chk("reset_pins", {red, green, blue, hsync, vsync}, IDLE);
      chk("reset_req", pix.pix_req, 0);
      chk("reset_fs", fs, 0);
    end else begin
      tk = enable && m_div == PD - 1;
      vis = m_h < HV && m_v < VV;
      chk("pix_req", pix.pix_req, tk && vis && mode == 2'd0);
      chk("frame_start", fs, tk && m_h == 0 && m_v == 0);
      if (tk) begin
        chk("pix_x", pix.pix_x, m_h);
        chk("pix_y", pix.pix_y, m_v);
        if (q.size() == 0) chk("queue_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("pins", {red, green, blue, hsync, vsync}, e);
        end
        q.push_back(exp_pins(m_h, m_v, mode));
        if (m_h == HT - 1) begin m_h = 0; m_v = m_v == VT - 1 ? 0 : m_v + 1; end
        else m_h = m_h + 1;
      end
      if (enable) m_div = tk ? 0 : m_div + 1;
    end
  end
  // External pixel source: returns {x, y, A} one clock after each request
  initial begin
    logic r;
    logic [CNT_W-1:0] x, y;
    pix.pix_rgb = '0;
    forever begin
      @(negedge clk);
      r = pix.pix_req; x = pix.pix_x; y = pix.pix_y;
      @(posedge clk);
      #1;
      if (r) pix.pix_rgb = {x[3:0], y[3:0], 4'hA};
    end
  end
  task automatic wait_pos(input int h, input int v);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (m_h == h && m_v == v) break;
    end
    chk("wait_pos_timeout", i < 5000, 1);
  endtask
  task automatic measure(input string nm, input bit is_v, input int lo_exp, input int per_exp);
    logic prev, cur;
    int n, lo;
    prev = 1'b0; cur = 1'b1;
    for (n = 0; n < 6000; n++) begin
      @(negedge clk);
      prev = cur; cur = is_v ? vsync : hsync;
      if (prev && !cur) break;
    end
    lo = 1;
    for (n = 1; n < 6000; n++) begin
      @(negedge clk);
      prev = cur; cur = is_v ? vsync : hsync;
      if (prev && !cur) break;
      if (!cur) lo++;
    end
    chk({nm, "_low"}, lo, lo_exp);
    chk({nm, "_period"}, n, per_exp);
  endtask
  initial begin
    int n, r;
    logic [3*CW+1:0] snap;
    logic [CNT_W-1:0] sx;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    for (n = 0; n < 5000 && !fs; n++) @(negedge clk);
    chk("first_fs", fs, 1);
    n = 0; r = 0;
    do begin
      @(negedge clk);
      n++;
      r += int'(pix.pix_req);
    end while (!fs && n < 5000);
    chk("frame_period", n, HT * VT * PD);
    chk("frame_reqs", r, HV * VV);
    measure("hsync", 1'b0, HS * PD, HT * PD);
    measure("vsync", 1'b1, VS * HT * PD, HT * VT * PD);
    for (int m = 1; m <= 4; m++) begin
      wait_pos(0, VV + 1);
      #1 mode = 2'(m);
      wait_pos(0, VV);
    end
    wait_pos(20, 5);
    #1 enable = 1'b0;
    snap = {red, green, blue, hsync, vsync};
    sx = pix.pix_x;
    repeat (10) @(posedge clk);
    #1;
    chk("freeze_pins", {red, green, blue, hsync, vsync}, snap);
    chk("freeze_x", pix.pix_x, sx);
    chk("freeze_req", pix.pix_req, 0);
    enable = 1'b1;
    wait_pos(25, 10);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pins", {red, green, blue, hsync, vsync}, IDLE);
    chk("async_rst_x", pix.pix_x, 0);
    chk("async_rst_req", pix.pix_req, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_pos(0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
